// File: rtl/rtsnoc_pkg.sv
// Shared definitions for the RTSNoC interrupt forwarder: header sizing,
// interrupt type codes, payload field layout and FSM encodings.
package rtsnoc_pkg;

    localparam int NOC_LOCAL_ADR_SIZE = 3;

    localparam int TYPE_LSB = 0;
    localparam int TYPE_W   = 2;
    localparam int CHAN_LSB = 2;
    localparam int CHAN_W   = 6;
    localparam int SEQ_LSB  = 8;
    localparam int SEQ_W    = 6;

    typedef enum logic [1:0] {
        INT_NONE  = 2'd0,
        INT_UP    = 2'd1,
        INT_DOWN  = 2'd2,
        INT_PULSE = 2'd3
    } int_type_e;

    typedef enum logic [1:0] {
        CH_IDLE = 2'd0,
        CH_ARM  = 2'd1,
        CH_HIGH = 2'd2
    } chan_state_e;

    typedef enum logic {
        TX_IDLE = 1'b0,
        TX_REQ  = 1'b1
    } tx_state_e;

    function automatic int soc_xy_size(input int sx, input int sy);
        return sx + sy;
    endfunction

    function automatic int noc_header_size(input int sx, input int sy);
        return 2 * (soc_xy_size(sx, sy) + NOC_LOCAL_ADR_SIZE);
    endfunction

    function automatic int noc_bus_size(input int sx, input int sy, input int dw);
        return noc_header_size(sx, sy) + dw;
    endfunction

endpackage

// File: rtl/rtsnoc_int_chan.sv
// One interrupt channel: edge classifier FSM plus a single-entry pending slot.
// A slot of INT_NONE means empty.
module rtsnoc_int_chan
    import rtsnoc_pkg::*;
(
    input  logic      clk_i,
    input  logic      rst_n_i,
    input  logic      i_int,
    input  logic      i_en,
    input  logic      i_clr,
    output logic      o_pend,
    output int_type_e o_type,
    output logic      o_arm
);

    chan_state_e r_state;
    chan_state_e w_next;
    int_type_e   r_type;
    int_type_e   w_set_type;
    logic        w_full;

    assign w_full = (r_type != INT_NONE);

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) r_state <= CH_IDLE;
        else          r_state <= w_next;
    end

    // The FSM reacts to the slot as registered, so a slot freed by TX this
    // edge is only refillable on the following edge.
    always_comb begin
        w_next = r_state;
        if (!i_en) begin
            w_next = CH_IDLE;
        end else begin
            case (r_state)
                CH_IDLE: if (i_int && !w_full)  w_next = CH_ARM;
                CH_ARM:  w_next = i_int ? CH_HIGH : CH_IDLE;
                CH_HIGH: if (!i_int && !w_full) w_next = CH_IDLE;
                default: w_next = CH_IDLE;
            endcase
        end
    end

    always_comb begin
        w_set_type = INT_NONE;
        if (i_en) begin
            case (r_state)
                CH_ARM:  w_set_type = i_int ? INT_UP : INT_PULSE;
                CH_HIGH: if (!i_int && !w_full) w_set_type = INT_DOWN;
                default: w_set_type = INT_NONE;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i)                  r_type <= INT_NONE;
        else if (!i_en || i_clr)       r_type <= INT_NONE;
        else if (w_set_type != INT_NONE) r_type <= w_set_type;
    end

    assign o_pend = w_full;
    assign o_type = r_type;
    assign o_arm  = (r_state == CH_ARM);

endmodule

// File: rtl/rtsnoc_int_tx_multi.sv
// Multi-channel interrupt forwarder: per-channel classifiers, round-robin
// pick of pending slots, one-packet TX handshake and inbound drain counter.
module rtsnoc_int_tx_multi
    import rtsnoc_pkg::*;
#(
    parameter int NUM_INT           = 4,
    parameter int NOC_DATA_WIDTH    = 32,
    parameter int NOC_LOCAL_ADR     = 0,
    parameter int NOC_X             = 0,
    parameter int NOC_Y             = 0,
    parameter int NOC_LOCAL_ADR_TGT = 0,
    parameter int NOC_X_TGT         = 0,
    parameter int NOC_Y_TGT         = 0,
    parameter int SOC_SIZE_X        = 1,
    parameter int SOC_SIZE_Y        = 1
)(
    input  logic                 clk_i,
    input  logic                 rst_n_i,
    input  logic [NUM_INT-1:0]   int_i,
    input  logic [NUM_INT-1:0]   int_en_i,
    output logic [noc_bus_size(SOC_SIZE_X, SOC_SIZE_Y, NOC_DATA_WIDTH)-1:0] noc_din_o,
    output logic                 noc_wr_o,
    output logic                 noc_rd_o,
    input  logic [noc_bus_size(SOC_SIZE_X, SOC_SIZE_Y, NOC_DATA_WIDTH)-1:0] noc_dout_i,
    input  logic                 noc_wait_i,
    input  logic                 noc_nd_i,
    output logic                 busy_o,
    output logic [7:0]           rx_drop_cnt_o
);

    localparam int NOC_HEADER_SIZE = noc_header_size(SOC_SIZE_X, SOC_SIZE_Y);
    localparam int NOC_BUS_SIZE    = noc_bus_size(SOC_SIZE_X, SOC_SIZE_Y, NOC_DATA_WIDTH);
    localparam int RRW             = (NUM_INT > 1) ? $clog2(NUM_INT) : 1;

    localparam logic [SOC_SIZE_X-1:0]         X_ORIG = NOC_X[SOC_SIZE_X-1:0];
    localparam logic [SOC_SIZE_Y-1:0]         Y_ORIG = NOC_Y[SOC_SIZE_Y-1:0];
    localparam logic [NOC_LOCAL_ADR_SIZE-1:0] L_ORIG = NOC_LOCAL_ADR[NOC_LOCAL_ADR_SIZE-1:0];
    localparam logic [SOC_SIZE_X-1:0]         X_DST  = NOC_X_TGT[SOC_SIZE_X-1:0];
    localparam logic [SOC_SIZE_Y-1:0]         Y_DST  = NOC_Y_TGT[SOC_SIZE_Y-1:0];
    localparam logic [NOC_LOCAL_ADR_SIZE-1:0] L_DST  = NOC_LOCAL_ADR_TGT[NOC_LOCAL_ADR_SIZE-1:0];

    logic [NUM_INT-1:0]        w_pend;
    logic [NUM_INT-1:0]        w_arm;
    logic [NUM_INT-1:0]        w_clr;
    int_type_e                 w_type [NUM_INT];
    logic [2*NUM_INT-1:0]      w_rot;
    logic                      w_found;
    logic [RRW-1:0]            w_pick;
    logic                      w_load;
    logic                      w_accept;
    logic [NOC_HEADER_SIZE-1:0] w_hdr;
    logic [NOC_DATA_WIDTH-1:0] w_data;
    logic                      w_unused_dout;

    tx_state_e                 r_tx_state;
    tx_state_e                 w_tx_next;
    logic [NOC_BUS_SIZE-1:0]   r_din;
    logic [RRW-1:0]            r_rr;
    logic [SEQ_W-1:0]          r_seq;
    logic                      r_rd;
    logic [7:0]                r_cnt;

    for (genvar g = 0; g < NUM_INT; g++) begin : g_chan
        rtsnoc_int_chan u_chan (
            .clk_i   (clk_i),
            .rst_n_i (rst_n_i),
            .i_int   (int_i[g]),
            .i_en    (int_en_i[g]),
            .i_clr   (w_clr[g]),
            .o_pend  (w_pend[g]),
            .o_type  (w_type[g]),
            .o_arm   (w_arm[g])
        );
        assign w_clr[g] = w_load && (w_pick == RRW'(g));
    end

    // Rotate the pending vector so bit 0 is the rr position; first set bit wins.
    assign w_rot = {w_pend, w_pend} >> r_rr;

    always_comb begin
        w_found = 1'b0;
        w_pick  = '0;
        for (int j = 0; j < NUM_INT; j++) begin
            if (!w_found && w_rot[j]) begin
                w_found = 1'b1;
                w_pick  = RRW'((int'(r_rr) + j) % NUM_INT);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) r_tx_state <= TX_IDLE;
        else          r_tx_state <= w_tx_next;
    end

    always_comb begin
        w_tx_next = r_tx_state;
        case (r_tx_state)
            TX_IDLE: if (w_found)     w_tx_next = TX_REQ;
            TX_REQ:  if (!noc_wait_i) w_tx_next = TX_IDLE;
            default: w_tx_next = TX_IDLE;
        endcase
    end

    always_comb begin
        w_load   = (r_tx_state == TX_IDLE) && w_found;
        w_accept = (r_tx_state == TX_REQ) && !noc_wait_i;
    end

    assign w_hdr = {X_ORIG, Y_ORIG, L_ORIG, X_DST, Y_DST, L_DST};

    always_comb begin
        w_data = '0;
        w_data[TYPE_LSB +: TYPE_W] = w_type[w_pick];
        w_data[CHAN_LSB +: CHAN_W] = CHAN_W'(w_pick);
        w_data[SEQ_LSB  +: SEQ_W]  = r_seq;
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            r_din <= '0;
            r_rr  <= '0;
            r_seq <= '0;
        end else begin
            if (w_load) begin
                r_din <= {w_hdr, w_data};
                if (int'(w_pick) == NUM_INT - 1) r_rr <= '0;
                else                             r_rr <= w_pick + 1'b1;
            end
            if (w_accept) r_seq <= r_seq + 1'b1;
        end
    end

    // Inbound packets are never consumed, only acknowledged and counted.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            r_rd  <= 1'b0;
            r_cnt <= '0;
        end else begin
            r_rd <= noc_nd_i;
            if (r_rd && r_cnt != 8'hFF) r_cnt <= r_cnt + 8'd1;
        end
    end

    assign w_unused_dout = ^noc_dout_i;

    assign noc_wr_o      = (r_tx_state == TX_REQ);
    assign noc_din_o     = r_din;
    assign noc_rd_o      = r_rd;
    assign rx_drop_cnt_o = r_cnt;
    assign busy_o        = (|w_pend) | noc_wr_o | (|w_arm);

endmodule

// File: tb/tb_rtsnoc_int_tx_multi.sv
// Bench for rtsnoc_int_tx_multi: directed scenarios plus randomized traffic
// compared every cycle against an event-level reference model.
module tb_rtsnoc_int_tx_multi;

    localparam int N  = 4;
    localparam int NB = 42;
    localparam logic [9:0] HDR = {1'b0, 1'b1, 3'd2, 1'b1, 1'b0, 3'd5};

    logic          clk_i = 1'b0;
    logic          rst_n_i = 1'b0;
    logic [N-1:0]  int_i = '0;
    logic [N-1:0]  int_en_i = '0;
    logic [NB-1:0] noc_din_o;
    logic          noc_wr_o;
    logic          noc_rd_o;
    logic [NB-1:0] noc_dout_i = '0;
    logic          noc_wait_i = 1'b0;
    logic          noc_nd_i = 1'b0;
    logic          busy_o;
    logic [7:0]    rx_drop_cnt_o;

    rtsnoc_int_tx_multi #(
        .NUM_INT(N), .NOC_DATA_WIDTH(32),
        .NOC_LOCAL_ADR(2), .NOC_X(0), .NOC_Y(1),
        .NOC_LOCAL_ADR_TGT(5), .NOC_X_TGT(1), .NOC_Y_TGT(0),
        .SOC_SIZE_X(1), .SOC_SIZE_Y(1)
    ) dut (
        .clk_i(clk_i), .rst_n_i(rst_n_i), .int_i(int_i), .int_en_i(int_en_i),
        .noc_din_o(noc_din_o), .noc_wr_o(noc_wr_o), .noc_rd_o(noc_rd_o),
        .noc_dout_i(noc_dout_i), .noc_wait_i(noc_wait_i), .noc_nd_i(noc_nd_i),
        .busy_o(busy_o), .rx_drop_cnt_o(rx_drop_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, act, exp, $time);
        end
    endtask

    // Reference model: what each channel has seen, what is queued, what is on the wire.
    int          m_mode [N];   // 0 = waiting, 1 = saw first high sample, 2 = known high
    int          m_pend [N];   // queued type code, 0 = nothing queued
    int          old_p  [N];
    bit          m_wr;
    logic [NB-1:0] m_pkt;
    int          m_rr, m_seq, m_cnt, m_pick;
    bit          m_rd;

    always @(posedge clk_i) begin
        if (!rst_n_i) begin
            for (int c = 0; c < N; c++) begin m_mode[c] = 0; m_pend[c] = 0; end
            m_wr = 0; m_rr = 0; m_seq = 0; m_cnt = 0; m_rd = 0; m_pkt = '0;
        end else begin
            for (int c = 0; c < N; c++) old_p[c] = m_pend[c];
            if (!m_wr) begin
                m_pick = -1;
                for (int k = 0; k < N; k++)
                    if (m_pick < 0 && old_p[(m_rr + k) % N] != 0) m_pick = (m_rr + k) % N;
                if (m_pick >= 0) begin
                    m_pkt = {HDR, 32'(old_p[m_pick] + m_pick * 4 + m_seq * 256)};
                    m_wr  = 1;
                    m_rr  = (m_pick + 1) % N;
                    m_pend[m_pick] = 0;
                end
            end else if (!noc_wait_i) begin
                m_seq = (m_seq + 1) % 64;
                m_wr  = 0;
            end
            for (int c = 0; c < N; c++) begin
                if (!int_en_i[c]) begin
                    m_mode[c] = 0; m_pend[c] = 0;
                end else if (m_mode[c] == 0) begin
                    if (int_i[c] && old_p[c] == 0) m_mode[c] = 1;
                end else if (m_mode[c] == 1) begin
                    m_pend[c] = int_i[c] ? 1 : 3;
                    m_mode[c] = int_i[c] ? 2 : 0;
                end else if (!int_i[c] && old_p[c] == 0) begin
                    m_pend[c] = 2; m_mode[c] = 0;
                end
            end
            if (m_rd && m_cnt < 255) m_cnt++;
            m_rd = noc_nd_i;
        end
    end

    logic [15:0] wr_log [$];
    int          rise_cyc [$];
    int          cyc = 0;
    bit          prev_wr = 0;

    task automatic step();
        bit exp_busy;
        @(posedge clk_i);
        #1;
        cyc++;
        exp_busy = m_wr;
        for (int c = 0; c < N; c++) if (m_pend[c] != 0 || m_mode[c] == 1) exp_busy = 1;
        chk_eq("wr", noc_wr_o, m_wr);
        if (m_wr) chk_eq("din", noc_din_o, m_pkt);
        chk_eq("busy", busy_o, exp_busy);
        chk_eq("rd", noc_rd_o, m_rd);
        chk_eq("cnt", rx_drop_cnt_o, m_cnt);
        if (noc_wr_o && !prev_wr) begin
            wr_log.push_back(noc_din_o[15:0]);
            rise_cyc.push_back(cyc);
        end
        prev_wr = noc_wr_o;
    endtask

    task automatic do_reset();
        rst_n_i = 1'b0; int_i = '0; noc_wait_i = 1'b0; noc_nd_i = 1'b0;
        step(); step();
        rst_n_i = 1'b1;
        wr_log.delete(); rise_cyc.delete();
    endtask

    task automatic pulse_ch0();
        int_i[0] = 1'b1; step();
        int_i[0] = 1'b0; repeat (4) step();
    endtask

    initial begin
        int_en_i = '1;
        do_reset();
        chk_eq("rst_wr", noc_wr_o, 0);
        chk_eq("rst_din", noc_din_o, 0);
        chk_eq("rst_busy", busy_o, 0);
        chk_eq("rst_cnt", rx_drop_cnt_o, 0);

        // single-cycle pulse on ch1
        int_i[1] = 1'b1; step();
        int_i[1] = 1'b0; step();
        chk_eq("pulse_e1_wr", noc_wr_o, 0);
        step();
        chk_eq("pulse_e2_wr", noc_wr_o, 1);
        chk_eq("pulse_data", noc_din_o[31:0], 32'h0000_0007);
        step();
        chk_eq("pulse_e3_wr", noc_wr_o, 0);
        repeat (10) step();
        chk_eq("pulse_count", wr_log.size(), 1);

        // long level on ch2: UP then DOWN
        do_reset();
        int_i[2] = 1'b1; repeat (10) step();
        int_i[2] = 1'b0; repeat (10) step();
        chk_eq("level_count", wr_log.size(), 2);
        if (wr_log.size() == 2) begin
            chk_eq("level_up", wr_log[0], 16'h0009);
            chk_eq("level_down", wr_log[1], 16'h010A);
        end

        // all channels rise together
        do_reset();
        int_i = 4'hF; repeat (12) step();
        chk_eq("rr_count", wr_log.size(), 4);
        if (wr_log.size() == 4) begin
            chk_eq("rr_ch0", wr_log[0], 16'h0001);
            chk_eq("rr_ch1", wr_log[1], 16'h0105);
            chk_eq("rr_ch2", wr_log[2], 16'h0209);
            chk_eq("rr_ch3", wr_log[3], 16'h030D);
            for (int i = 0; i < 3; i++) chk_eq("rr_gap", rise_cyc[i+1] - rise_cyc[i], 2);
        end
        int_i = 4'h0; repeat (12) step();

        // router stall during TX_REQ
        do_reset();
        int_i[0] = 1'b1; step();
        int_i[0] = 1'b0; step(); step();
        noc_wait_i = 1'b1;
        repeat (5) begin
            step();
            chk_eq("stall_wr", noc_wr_o, 1);
            chk_eq("stall_din", noc_din_o[31:0], 32'h0000_0003);
        end
        noc_wait_i = 1'b0; step();
        chk_eq("stall_accept", noc_wr_o, 0);
        pulse_ch0();
        chk_eq("stall_seq", wr_log[wr_log.size()-1], 16'h0103);

        // sequence wrap and drop counter saturation
        do_reset();
        repeat (63) pulse_ch0();
        pulse_ch0();
        chk_eq("seq_63", wr_log[wr_log.size()-1], 16'h3F03);
        pulse_ch0();
        chk_eq("seq_wrap", wr_log[wr_log.size()-1], 16'h0003);
        repeat (300) begin
            noc_nd_i = 1'b1; step();
            noc_nd_i = 1'b0; step();
        end
        step();
        chk_eq("drop_sat", rx_drop_cnt_o, 8'd255);

        // disabling a high channel suppresses its DOWN
        do_reset();
        int_i[3] = 1'b1; repeat (6) step();
        int_en_i[3] = 1'b0; step();
        int_i[3] = 1'b0; step();
        int_en_i = '1; repeat (6) step();
        chk_eq("dis_count", wr_log.size(), 1);
        chk_eq("dis_up", wr_log[0], 16'h000D);

        // reset while a packet is on the wire
        do_reset();
        int_i[0] = 1'b1; step();
        int_i[0] = 1'b0; step(); step();
        noc_wait_i = 1'b1; step();
        rst_n_i = 1'b0; step();
        chk_eq("rst_tx_wr", noc_wr_o, 0);
        chk_eq("rst_tx_din", noc_din_o, 0);
        chk_eq("rst_tx_busy", busy_o, 0);
        rst_n_i = 1'b1; noc_wait_i = 1'b0;

        // randomized traffic against the model
        for (int t = 0; t < 3000; t++) begin
            for (int c = 0; c < N; c++) begin
                if ($urandom_range(0, 5) == 0) int_i[c] = ~int_i[c];
                if ($urandom_range(0, 49) == 0) int_en_i[c] = ~int_en_i[c];
            end
            noc_wait_i = ($urandom_range(0, 9) < 3);
            noc_nd_i   = $urandom_range(0, 1) == 1;
            noc_dout_i = {$urandom, $urandom};
            rst_n_i    = ($urandom_range(0, 499) != 0);
            step();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/rtsnoc_int_tx_multi.md
Name: rtsnoc_int_tx_multi

Overview:
Multi-channel interrupt forwarder for the RTSNoC router local port. It watches NUM_INT synchronous interrupt lines and classifies each event as PULSE, UP or DOWN. Each event is sent as one packet to a fixed target node, with round-robin arbitration between channels. Inbound traffic on the port is drained and counted. It supersedes the single-line interrupt transmitter.

Parameters:
NUM_INT, 4, interrupt channels (1..64)
NOC_DATA_WIDTH, 32, payload width (>=16)
NOC_LOCAL_ADR / NOC_X / NOC_Y, 0/0/0, own node address
NOC_LOCAL_ADR_TGT / NOC_X_TGT / NOC_Y_TGT, 0/0/0, target node address
SOC_SIZE_X / SOC_SIZE_Y, 1/1, log2 of mesh dimensions

Ports:
clk_i  in  1  clock
rst_n_i  in  1  reset, synchronous, active-low
int_i  in  NUM_INT  interrupt levels, synchronous to clk_i
int_en_i  in  NUM_INT  per-channel enable
noc_din_o  out  NOC_BUS_SIZE  packet to router {X_orig,Y_orig,local_orig,X_dst,Y_dst,local_dst,data}
noc_wr_o  out  1  write request
noc_rd_o  out  1  read strobe
noc_dout_i  in  NOC_BUS_SIZE  packet from router
noc_wait_i  in  1  router busy
noc_nd_i  in  1  router has data
busy_o  out  1  any event pending or in flight
rx_drop_cnt_o  out  8  drained inbound packets, saturating

Behaviour:
- Reset (rst_n_i=0 at a clk_i edge): all outputs 0; channel FSMs IDLE; pending slots empty; rr pointer 0; seq 0; drop counter 0.
- Payload: data[1:0]=type (UP=1, DOWN=2, PULSE=3); data[7:2]=channel index; data[13:8]=6-bit seq; rest 0. Header comes from parameters.
- Per-channel FSM and 1-entry pending slot. Edge E0 = first edge sampling int=1.
  - IDLE: int=1 and slot empty -> ARM. If the slot is full, stay IDLE.
  - ARM: int=0 -> slot=PULSE, go IDLE. int=1 -> slot=UP, go HIGH. The slot is always empty on entry to ARM.
  - HIGH: int=0 and slot empty -> slot=DOWN, go IDLE. If the slot is full, stay HIGH.
- Stalls are level-consistent; pulses shorter than the stall are lost by design.
- int_en=0: channel forced IDLE and its pending slot cleared, with no DOWN sent. A packet already loaded or in flight completes. If clear and load coincide, the load wins.
- TX FSM:
  - TX_IDLE: if any slot is full, pick the first full slot at or after rr (wrapping). Load the packet, clear that slot, raise noc_wr_o, set rr = chosen+1 mod NUM_INT, go TX_REQ.
  - TX_REQ: hold noc_wr_o and noc_din_o stable until an edge with noc_wait_i=0 (accept). Then seq++ (wraps 63->0), drop noc_wr_o, go TX_IDLE.
  - Maximum throughput: 1 packet per 2 cycles.
- Latency, uncontended, noc_wait_i=0:
  - int rises at E0 -> noc_wr_o=1 after E2.
  - Accepted at E3; noc_wr_o=0 after E3.
- A slot cleared by TX frees the channel the same edge; the FSM may refill it on the next edge.
- Inbound drain: noc_rd_o is registered and equals noc_nd_i from the previous edge, held to 1 for one cycle per packet. Each rd pulse increments rx_drop_cnt_o, saturating at 255. Contents of noc_dout_i are ignored.
- busy_o = OR of slots | noc_wr_o | any FSM in ARM.
- Reset mid-transfer: noc_wr_o drops at that edge; the packet is lost and not retried.

Decomposition:
- Shared package rtsnoc_pkg: header-size localparams (SOC_XY_SIZE, NOC_HEADER_SIZE, NOC_BUS_SIZE), type codes, payload field offsets.
- Sub-module rtsnoc_int_chan: one channel FSM plus its slot, instantiated with generate. Round-robin arbiter and TX stay in the top level.

Test Plan:
- NUM_INT=4. ch1 high 1 cycle -> one packet after E2, data=0x0007 (PULSE, ch1, seq0), then nothing.
- ch2 high 10 cycles -> UP data=0x0009 (seq0), then DOWN data=0x010A (seq1); noc_wr_o never asserted more than 2 times.
- ch0..ch3 rise at the same edge, noc_wait_i=0 -> UP packets in order ch0,1,2,3, each 2 cycles apart; seq 0..3.
- noc_wait_i=1 for 5 cycles during TX_REQ -> noc_din_o stable, noc_wr_o=1 throughout; accepted on the first low cycle; seq increments once.
- 64 pulses on ch0 -> seq wraps to 0. noc_nd_i pulsed 300 times -> rx_drop_cnt_o=255.
- ch3 in HIGH, int_en_i[3] cleared -> no DOWN sent. rst_n_i=0 during TX_REQ -> all outputs 0 on the next edge.
